// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch stage: branch-unit pc_src codes, fetch FSM states, word size.
package fetch_unit_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDiscard,
    StFull
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/next_pc_calc.sv
// Redirect target for the instruction in IF/ID, selected by the branch unit's pc_src decision.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [1:0]  pc_src,
  input  logic [31:0] if_id_pc4,
  input  logic [15:0] br_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] target
);

  always_comb begin
    target = if_id_pc4;
    unique case (pc_src)
      PC_BR:   target = if_id_pc4 + {{14{br_offset[15]}}, br_offset, 2'b00};
      PC_J:    target = {if_id_pc4[31:28], jump_index, 2'b00};
      PC_JR:   target = {jr_target[31:2], 2'b00};
      default: target = if_id_pc4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one-at-a-time imem fetches and fills IF/ID, with a
// one-entry skid for data that returns while decode is stalled.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          pc_src,
  input  logic [15:0]         br_offset,
  input  logic [25:0]         jump_index,
  input  logic [31:0]         jr_target,
  input  logic                stall,
  fetch_unit_if.master        imem,
  output logic                if_id_valid,
  output logic [31:0]         if_id_instr,
  output logic [31:0]         if_id_pc4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_addr_q, skid_addr_d;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  addr_next;

  assign redirect  = valid_q & ~stall & (pc_src != PC_SEQ);
  assign addr_next = addr_q + WORD_BYTES;

  next_pc_calc u_next_pc_calc (
    .pc_src     (pc_src),
    .if_id_pc4  (pc4_q),
    .br_offset  (br_offset),
    .jump_index (jump_index),
    .jr_target  (jr_target),
    .target     (target)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;

    // No delay slot: a redirect kills IF/ID; a consumed entry drains unless refilled below.
    if (redirect || (valid_q && !stall)) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        state_d = StWait;
        addr_d  = pc_q;
      end
      StWait: begin
        if (redirect) begin
          pc_d = target;
          if (imem.imem_ack) begin
            addr_d = target;
          end else begin
            state_d = StDiscard;
          end
        end else if (imem.imem_ack) begin
          pc_d   = addr_next;
          addr_d = addr_next;
          if (valid_q && stall) begin
            skid_instr_d = imem.imem_rdata;
            skid_addr_d  = addr_q;
            state_d      = StFull;
          end else begin
            valid_d = 1'b1;
            instr_d = imem.imem_rdata;
            pc4_d   = addr_next;
          end
        end
      end
      StDiscard: begin
        if (redirect) begin
          pc_d = target;
        end
        if (imem.imem_ack) begin
          state_d = StWait;
          addr_d  = pc_d;
        end
      end
      StFull: begin
        if (redirect) begin
          pc_d    = target;
          addr_d  = target;
          state_d = StWait;
        end else if (!stall) begin
          valid_d = 1'b1;
          instr_d = skid_instr_q;
          pc4_d   = skid_addr_q + WORD_BYTES;
          addr_d  = pc_q;
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= 32'd0;
      pc4_q        <= 32'd0;
      skid_instr_q <= 32'd0;
      skid_addr_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
    end
  end

  assign imem.imem_req  = (state_q == StWait) || (state_q == StDiscard);
  assign imem.imem_addr = addr_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc4      = pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Random-latency memory and random decode behaviour; checks that decode sees exactly the
// architectural instruction stream, plus handshake, skid and reset properties.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_src;
  logic [15:0] br_offset;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic        stall;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_src      (pc_src),
    .br_offset   (br_offset),
    .jump_index  (jump_index),
    .jr_target   (jr_target),
    .stall       (stall),
    .imem        (bus.master),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4)
  );

  always #5 clk = ~clk;

  int unsigned vectors;
  int unsigned miscompares;
  logic [31:0] exp_pc;       // address of the next instruction decode must see
  logic [31:0] held_instr;
  logic [31:0] held_pc4;
  logic        held_prev;
  logic        skid_expected;
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_delay;
  int          idle_cnt;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_target(input logic [1:0] src, input logic [31:0] pc4,
                                             input logic [15:0] off, input logic [25:0] idx,
                                             input logic [31:0] jr);
    int soff;
    soff = int'($signed(off));
    if (src == 2'b01) return pc4 + 32'(soff * 4);
    if (src == 2'b10) return (pc4 & 32'hF000_0000) + (32'(idx) * 32'd4);
    return jr - (jr % 32'd4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc        = RESET_PC;
    held_prev     = 1'b0;
    skid_expected = 1'b0;
    mem_busy      = 1'b0;
    mem_delay     = 0;
    idle_cnt      = 0;
  endtask

  task automatic step();
    @(negedge clk);
    if (mem_busy) begin
      chk("req_held", 32'(bus.imem_req), 32'd1);
      chk("addr_held", bus.imem_addr, mem_addr);
    end
    if (skid_expected) chk("skid_no_req", 32'(bus.imem_req), 32'd0);
    if (bus.imem_req) chk("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
    if (if_id_valid) begin
      idle_cnt = 0;
      if (held_prev) begin
        chk("hold_instr", if_id_instr, held_instr);
        chk("hold_pc4", if_id_pc4, held_pc4);
      end else begin
        chk("stream_pc4", if_id_pc4, exp_pc + 32'd4);
        chk("stream_instr", if_id_instr, memf(exp_pc));
      end
    end else begin
      idle_cnt++;
    end
    vectors++;
    assert (idle_cnt < 64)
    else begin
      miscompares++;
      $error("FAIL liveness: observed %0d idle cycles expected < 64", idle_cnt);
      idle_cnt = 0;
    end

    stall      = ($urandom_range(0, 3) == 0);
    pc_src     = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : PC_SEQ;
    br_offset  = 16'($urandom);
    jump_index = 26'($urandom);
    jr_target  = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
    if (if_id_valid && !stall) begin
      exp_pc = (pc_src == PC_SEQ) ? if_id_pc4
             : ref_target(pc_src, if_id_pc4, br_offset, jump_index, jr_target);
    end

    if (bus.imem_req && !mem_busy) begin
      mem_busy  = 1'b1;
      mem_addr  = bus.imem_addr;
      mem_delay = int'($urandom_range(0, 3));
    end
    if (mem_busy && mem_delay == 0) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = memf(mem_addr);
      mem_busy       = 1'b0;
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      if (mem_busy) mem_delay--;
    end

    // Data returning while decode is stalled parks in the skid; no further fetch until drained.
    skid_expected = if_id_valid && stall && (skid_expected || bus.imem_ack);
    held_prev     = if_id_valid && stall;
    held_instr    = if_id_instr;
    held_pc4      = if_id_pc4;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    stall          = 1'b0;
    pc_src         = PC_SEQ;
    br_offset      = 16'd0;
    jump_index     = 26'd0;
    jr_target      = 32'd0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    mem_addr       = 32'd0;
    held_instr     = 32'd0;
    held_pc4       = 32'd0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instr, 32'd0);
    chk("rst_pc4", if_id_pc4, 32'd0);
    rst = 1'b0;

    repeat (2000) step();

    // Reset in the middle of an outstanding request.
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.imem_req) break;
    end
    chk("mid_req_before_rst", 32'(bus.imem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(bus.imem_req), 32'd0);
    chk("async_rst_addr", bus.imem_addr, RESET_PC);
    chk("async_rst_valid", 32'(if_id_valid), 32'd0);
    @(negedge clk);
    // Late ack arriving while the fetch unit sits in its post-reset idle cycle.
    rst            = 1'b0;
    stall          = 1'b0;
    pc_src         = PC_SEQ;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    model_reset();

    repeat (500) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the branch unit: consumes its 2-bit pc_src decision and owns the program counter.
- Issues word fetches to instruction memory over a req/ack handshake.
- Presents fetched instructions to decode through the IF/ID register.
- Handles hazard stalls, branch/jump redirects, flushes and in-flight fetch discard.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first address fetched.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- pc_src  input  2  branch unit decision: 00 sequential, 01 conditional branch taken, 10 jump (j/jal), 11 register jump (jr/jalr)
- br_offset  input  16  immediate field of the instruction in IF/ID
- jump_index  input  26  target field of the instruction in IF/ID
- jr_target  input  32  rs value from the register file
- stall  input  1  hazard unit holds IF/ID
- imem_req  output  1  fetch request
- imem_addr  output  32  word-aligned fetch address
- imem_ack  input  1  one-cycle pulse; imem_rdata valid
- imem_rdata  input  32  fetched instruction
- if_id_valid  output  1  IF/ID holds a live instruction
- if_id_instr  output  32  instruction to decode
- if_id_pc4  output  32  address of that instruction + 4

Behaviour:
- Reset:
  - Asynchronous, active-high, single clock domain.
  - Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc4=0, state=IDLE.
  - Reset mid-fetch abandons the request; a late ack is ignored while in IDLE.
- Redirect:
  - redirect = if_id_valid & ~stall & (pc_src != 00).
  - pc_src is ignored otherwise.
- Targets (32-bit, modulo 2^32):
  - 01: if_id_pc4 + (sext(br_offset) << 2)
  - 10: {if_id_pc4[31:28], jump_index, 2'b00}
  - 11: jr_target with bits [1:0] forced to 0
- No delay slot: on redirect, if_id_valid <= 0 that cycle and any data acked that cycle is dropped.
- Sequential PC: pc+4 wraps 32'hFFFF_FFFC -> 0.
- Handshake:
  - imem_req and imem_addr are held stable from assertion until the ack cycle.
  - At most one request outstanding.
  - The next request may be issued in the cycle after ack.
- FSM states and transitions:
  - IDLE: req=0. Next cycle -> WAIT with addr=pc.
  - WAIT: req=1.
    - ack & redirect: drop data; pc<=target; stay WAIT, new addr=target next cycle.
    - ack & (~if_id_valid | ~stall): load IF/ID {rdata, addr+4, valid=1}; pc<=addr+4; stay WAIT at pc+4.
    - ack & if_id_valid & stall: capture rdata in skid register; pc<=addr+4; -> FULL.
    - ~ack & redirect: pc<=target; -> DISCARD; addr held.
  - DISCARD: req=1, old addr.
    - Further redirects overwrite pc with the newest target.
    - On ack: drop data; -> WAIT at pc.
  - FULL: req=0.
    - redirect: drop skid; pc<=target; -> WAIT.
    - ~stall: move skid into IF/ID (valid=1, pc4=skid addr+4); -> WAIT at pc.
- Stall with no redirect: IF/ID holds all fields unchanged.
- If IF/ID drains (consumed with no replacement): if_id_valid <= 0.

Decomposition:
- Shared package:
  - pc_src encodings PC_SEQ=2'b00, PC_BR=2'b01, PC_J=2'b10, PC_JR=2'b11, identical to the branch unit's.
  - FSM state encodings IDLE/WAIT/DISCARD/FULL.
  - Word size constant 4.
- One combinational sub-module, next_pc_calc: inputs pc_src, if_id_pc4, br_offset, jump_index, jr_target; output target.
  - Reusable by the branch unit testbench for checking.

Test Plan:
- Reset release, memory acks the cycle after each req -> addresses 0,4,8,12 fetched back-to-back; if_id_pc4 = 4,8,12,16.
- Branch redirect: IF/ID holds instr at 0x10 (pc4=0x14), br_offset=16'hFFFC, pc_src=01, stall=0, ack same cycle -> acked data dropped, if_id_valid=0, next imem_addr=0x04.
- Redirect while request at 0x20 is unacked (ack delayed 3 cycles), jump with jump_index=26'h40 -> imem_addr stays 0x20 until ack, data dropped, next request at 0x100.
- stall=1 for 4 cycles with IF/ID valid -> one fetch captured to skid, req=0, IF/ID unchanged; stall drop -> skid moves to IF/ID, fetch resumes at next sequential address.
- pc_src=11, jr_target=0x0000_0203 -> next fetch address 0x0000_0200; pc_src=01 with stall=1 -> ignored, no redirect.
- PC at 0xFFFF_FFFC, sequential fetch -> next imem_addr 0x0000_0000; rst asserted mid-request -> imem_req=0 immediately, restart from RESET_PC.
